// File: rtl/btn_gates_debounced.sv
//==============================================================================
// Module : btn_gates_debounced
// Brief  : Per-button sync + debounce, AND/OR/XOR reductions and a press toggle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module btn_gates_debounced #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_BTN-1:0] BTN,
  output logic [3:0]       LED
);

  localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] r_stable;
  logic             r_prev0;
  logic             r_toggle;
  logic             w_press;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= BTN;
      r_s2 <= r_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [c_CNT_W-1:0] r_cnt;

      // Any cycle of agreement restarts the count, so the counter never wraps.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          r_cnt        <= '0;
          r_stable[gi] <= 1'b0;
        end else if (r_s2[gi] == r_stable[gi]) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_cnt        <= '0;
          r_stable[gi] <= r_s2[gi];
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  endgenerate

  assign w_press = r_stable[0] & ~r_prev0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_prev0  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_prev0 <= r_stable[0];
      if (w_press) begin
        r_toggle <= ~r_toggle;
      end
    end
  end

  // Reductions look only at debounced state, keeping the LEDs glitch-free.
  assign LED[0] = &r_stable;
  assign LED[1] = |r_stable;
  assign LED[2] = ^r_stable;
  assign LED[3] = r_toggle;

endmodule

`default_nettype wire

// File: tb/tb_btn_gates_debounced.sv
//==============================================================================
// Module : tb_btn_gates_debounced
// Brief  : Directed scoreboard bench for btn_gates_debounced.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_gates_debounced;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_a;
  logic [3:0] led_a;
  logic [0:0] btn_b;
  logic [3:0] led_b;

  always #5 clk = ~clk;

  btn_gates_debounced #(.N_BTN(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .CLK(clk), .RESET(rst), .BTN(btn_a), .LED(led_a)
  );

  btn_gates_debounced #(.N_BTN(1), .DEBOUNCE_CYCLES(1)) dut_b (
    .CLK(clk), .RESET(rst), .BTN(btn_b), .LED(led_b)
  );

  typedef struct {
    string      tag;
    int         due;
    bit         on_b;
    logic [3:0] exp;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp, input logic [3:0] mask);
    checks++;
    assert ((got & mask) === (exp & mask))
    else begin
      errors++;
      $error("FAIL %s: got %b expected %b (mask %b)", tag, got, exp, mask);
    end
  endtask

  task automatic check_cnt1(input string tag);
    checks++;
    assert (dut_a.g_btn[1].r_cnt <= 2'd1)
    else begin
      errors++;
      $error("FAIL %s: cnt[1] got %0d expected <= 1", tag, dut_a.g_btn[1].r_cnt);
    end
  endtask

  // Expect value after edge E<k>, where E0 is the next rising edge.
  task automatic push(input string tag, input int k, input logic [3:0] exp,
                      input logic [3:0] mask, input bit on_b);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + k + 1;
    e.on_b = on_b;
    e.exp  = exp;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check(e.tag, e.on_b ? led_b : led_a, e.exp, e.mask);
      end
    end
  endtask

  initial begin
    logic b;
    logic b_prev;
    logic exp_tog;

    rst   = 1'b1;
    btn_a = 2'b11;
    btn_b = 1'b0;
    #2;
    check("rst_async_a", led_a, 4'b0000, 4'hF);
    check("rst_async_b", led_b, 4'b0000, 4'hF);
    for (int i = 0; i < 3; i++) begin
      push("rst_hold_a", 0, 4'b0000, 4'hF, 1'b0);
      push("rst_hold_b", 0, 4'b0000, 4'hF, 1'b1);
      run(1);
    end

    // Buttons held through reset release are re-debounced and give one toggle.
    rst = 1'b0;
    push("rel_e4", 4, 4'b0000, 4'hF, 1'b0);
    push("rel_e5", 5, 4'b0011, 4'hF, 1'b0);
    push("rel_e6", 6, 4'b1011, 4'hF, 1'b0);
    run(7);

    rst   = 1'b1;
    btn_a = 2'b00;
    #1;
    check("mid_rst_async", led_a, 4'b0000, 4'hF);
    push("mid_rst_hold", 0, 4'b0000, 4'hF, 1'b0);
    run(2);
    rst = 1'b0;
    push("post_rst", 1, 4'b0000, 4'hF, 1'b0);
    run(2);

    btn_a = 2'b01;
    push("press_e4", 4, 4'b0000, 4'hF, 1'b0);
    push("press_e5", 5, 4'b0110, 4'hF, 1'b0);
    push("press_e6", 6, 4'b1110, 4'hF, 1'b0);
    run(7);

    btn_a = 2'b00;
    push("release_e4", 4, 4'b1110, 4'hF, 1'b0);
    push("release_e5", 5, 4'b1000, 4'hF, 1'b0);
    push("release_e6", 6, 4'b1000, 4'hF, 1'b0);
    run(7);

    for (int i = 0; i < 4; i++) begin
      btn_a = (i % 2 == 0) ? 2'b10 : 2'b00;
      push("bounce", 0, 4'b1000, 4'hF, 1'b0);
      run(1);
      check_cnt1("bounce_cnt");
    end
    btn_a = 2'b00;
    for (int i = 0; i < 8; i++) begin
      push("bounce_rest", 0, 4'b1000, 4'hF, 1'b0);
      run(1);
      check_cnt1("bounce_rest_cnt");
    end

    btn_a = 2'b01;
    for (int k = 0; k < 3; k++) push("nearmiss3_on", k, 4'b1000, 4'hF, 1'b0);
    run(3);
    btn_a = 2'b00;
    for (int i = 0; i < 8; i++) begin
      push("nearmiss3_off", 0, 4'b1000, 4'hF, 1'b0);
      run(1);
    end

    btn_a = 2'b01;
    for (int k = 0; k < 4; k++) push("accept4_on", k, 4'b1000, 4'hF, 1'b0);
    run(4);
    btn_a = 2'b00;
    push("accept4_e4", 0, 4'b1000, 4'hF, 1'b0);
    push("accept4_e5", 1, 4'b1110, 4'hF, 1'b0);
    push("accept4_e6", 2, 4'b0110, 4'hF, 1'b0);
    push("accept4_e8", 4, 4'b0110, 4'hF, 1'b0);
    push("accept4_e9", 5, 4'b0000, 4'hF, 1'b0);
    run(6);

    btn_a = 2'b11;
    for (int k = 0; k < 5; k++) push("simul_wait", k, 4'b0000, 4'hF, 1'b0);
    push("simul_e5", 5, 4'b0011, 4'hF, 1'b0);
    push("simul_e6", 6, 4'b1011, 4'hF, 1'b0);
    run(7);

    // Single-button, one-cycle debounce: LED[2:0] lags BTN by three edges.
    b_prev  = 1'b0;
    exp_tog = 1'b0;
    for (int t = 0; t < 32; t++) begin
      b     = ((t / 4) % 2) == 1;
      btn_b = b;
      push("sweep_led", 2, {1'b0, b, b, b}, 4'b0111, 1'b1);
      if (b && !b_prev) exp_tog = ~exp_tog;
      push("sweep_tog", 3, {exp_tog, 3'b000}, 4'b1000, 1'b1);
      b_prev = b;
      run(1);
    end
    btn_b = 1'b0;
    run(5);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
